// File: rtl/operand_loader.sv
// operand_loader: collects four serial words (op_1_re, op_1_im, op_2_re,
// op_2_im) into one operand set and hands it to a downstream multiplier
// with a valid/ready handshake.
// Build option: define OPERAND_DOUBLE_BUF_EN to add a second set buffer so
// collection continues while a completed set waits for the multiplier.
module operand_loader #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  sw_rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_val,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] op_1_re,
  output logic [DATA_WIDTH-1:0] op_1_im,
  output logic [DATA_WIDTH-1:0] op_2_re,
  output logic [DATA_WIDTH-1:0] op_2_im,
  output logic                  op_val,
  input  logic                  op_ready,
  output logic [1:0]            word_idx
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [DATA_WIDTH-1:0] col_q   [3];
  logic [DATA_WIDTH-1:0] col_d   [3];
  logic [DATA_WIDTH-1:0] pres_q  [4];
  logic [DATA_WIDTH-1:0] pres_d  [4];
  logic [DATA_WIDTH-1:0] new_set [4];
  logic                  accept;
  logic                  complete;
  logic                  transfer;

`ifdef OPERAND_DOUBLE_BUF_EN
  logic [DATA_WIDTH-1:0] pend_q [4];
  logic [DATA_WIDTH-1:0] pend_d [4];
  logic                  pend_val_q, pend_val_d;

  // Stall input only when both the presented and the waiting set are full.
  assign in_ready = !((state_q == ST_FULL) && pend_val_q);
`else
  // Single buffer: collection pauses while a set is presented.
  assign in_ready = (state_q == ST_EMPTY);
`endif

  assign accept   = in_val & in_ready;
  assign complete = accept & (idx_q == 2'd3);
  assign transfer = (state_q == ST_FULL) & op_ready;

  // The last word goes straight into the completed set; the others come
  // from the collection registers.
  assign new_set[0] = col_q[0];
  assign new_set[1] = col_q[1];
  assign new_set[2] = col_q[2];
  assign new_set[3] = in_data;

  // Word collection: store words 0..2 and advance the word index.
  always_comb begin
    idx_d = idx_q;
    col_d = col_q;
    if (accept) begin
      idx_d = idx_q + 2'd1;
      case (idx_q)
        2'd0:    col_d[0] = in_data;
        2'd1:    col_d[1] = in_data;
        2'd2:    col_d[2] = in_data;
        default: ;
      endcase
    end
    if (sw_rst) begin
      idx_d = 2'd0;
      for (int i = 0; i < 3; i++) col_d[i] = '0;
    end
  end

`ifdef OPERAND_DOUBLE_BUF_EN
  // Output buffering: presented set plus one waiting set, kept in order.
  always_comb begin
    state_d    = state_q;
    pres_d     = pres_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    if (transfer) begin
      if (pend_val_q) begin
        pres_d     = pend_q;
        pend_val_d = 1'b0;
        if (complete) begin
          pend_d     = new_set;
          pend_val_d = 1'b1;
        end
      end else if (complete) begin
        pres_d = new_set;
      end else begin
        state_d = ST_EMPTY;
      end
    end else if (complete) begin
      if (state_q == ST_EMPTY) begin
        pres_d  = new_set;
        state_d = ST_FULL;
      end else begin
        pend_d     = new_set;
        pend_val_d = 1'b1;
      end
    end
    if (sw_rst) begin
      state_d    = ST_EMPTY;
      pend_val_d = 1'b0;
      for (int i = 0; i < 4; i++) begin
        pres_d[i] = '0;
        pend_d[i] = '0;
      end
    end
  end
`else
  // Output buffering: one set, EMPTY until completion, FULL until transfer.
  always_comb begin
    state_d = state_q;
    pres_d  = pres_q;
    if (complete) begin
      pres_d  = new_set;
      state_d = ST_FULL;
    end else if (transfer) begin
      state_d = ST_EMPTY;
    end
    if (sw_rst) begin
      state_d = ST_EMPTY;
      for (int i = 0; i < 4; i++) pres_d[i] = '0;
    end
  end
`endif

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_EMPTY;
      idx_q   <= 2'd0;
      for (int i = 0; i < 3; i++) col_q[i] <= '0;
      for (int i = 0; i < 4; i++) pres_q[i] <= '0;
`ifdef OPERAND_DOUBLE_BUF_EN
      for (int i = 0; i < 4; i++) pend_q[i] <= '0;
      pend_val_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      col_q   <= col_d;
      pres_q  <= pres_d;
`ifdef OPERAND_DOUBLE_BUF_EN
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
`endif
    end
  end

  assign op_val   = (state_q == ST_FULL);
  assign op_1_re  = pres_q[0];
  assign op_1_im  = pres_q[1];
  assign op_2_re  = pres_q[2];
  assign op_2_im  = pres_q[3];
  assign word_idx = idx_q;

endmodule

// File: tb/tb_operand_loader.sv
// Directed testbench for operand_loader. Inputs change and outputs are
// sampled on the falling clock edge, away from the capturing rising edge.
module tb_operand_loader;

  logic       clk;
  logic       rstn;
  logic       sw_rst;
  logic [7:0] in_data;
  logic       in_val;
  logic       in_ready;
  logic [7:0] op_1_re, op_1_im, op_2_re, op_2_im;
  logic       op_val;
  logic       op_ready;
  logic [1:0] word_idx;

  int checks = 0;
  int errors = 0;

  operand_loader #(.DATA_WIDTH(8)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .sw_rst   (sw_rst),
    .in_data  (in_data),
    .in_val   (in_val),
    .in_ready (in_ready),
    .op_1_re  (op_1_re),
    .op_1_im  (op_1_im),
    .op_2_re  (op_2_re),
    .op_2_im  (op_2_im),
    .op_val   (op_val),
    .op_ready (op_ready),
    .word_idx (word_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ops(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
    chk({tag, "_op1re"}, {24'd0, op_1_re}, {24'd0, a});
    chk({tag, "_op1im"}, {24'd0, op_1_im}, {24'd0, b});
    chk({tag, "_op2re"}, {24'd0, op_2_re}, {24'd0, c});
    chk({tag, "_op2im"}, {24'd0, op_2_im}, {24'd0, d});
  endtask

  // Drive four words on consecutive cycles; returns on the falling edge
  // after the fourth capture edge with in_val dropped.
  task automatic feed4(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    in_val = 1'b1;
    in_data = a; @(negedge clk);
    in_data = b; @(negedge clk);
    in_data = c; @(negedge clk);
    in_data = d; @(negedge clk);
    in_val = 1'b0;
  endtask

  initial begin
    logic [7:0] alt [4];
    int         acc;

    rstn = 1'b1; sw_rst = 1'b0; in_val = 1'b0; in_data = 8'h00; op_ready = 1'b0;
    #1 rstn = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_opval", {31'd0, op_val}, 32'd0);
    chk("rst_idx", {30'd0, word_idx}, 32'd0);
    chk_ops("rst", 8'h00, 8'h00, 8'h00, 8'h00);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_inready", {31'd0, in_ready}, 32'd1);

    // Back-to-back set with the multiplier always ready.
    op_ready = 1'b1;
    feed4(8'h03, 8'h04, 8'h05, 8'h06);
    chk("b2b_opval", {31'd0, op_val}, 32'd1);
    chk_ops("b2b", 8'h03, 8'h04, 8'h05, 8'h06);
    chk("b2b_idx", {30'd0, word_idx}, 32'd0);
`ifndef OPERAND_DOUBLE_BUF_EN
    chk("b2b_inready", {31'd0, in_ready}, 32'd0);
`endif
    @(negedge clk);
    chk("b2b_opval_after", {31'd0, op_val}, 32'd0);
    chk("b2b_inready_after", {31'd0, in_ready}, 32'd1);

    // Backpressure: set held for 10 cycles while 0xAA is offered.
    op_ready = 1'b0;
    feed4(8'h11, 8'h22, 8'h33, 8'h44);
    in_val = 1'b1; in_data = 8'hAA;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_opval", {31'd0, op_val}, 32'd1);
      chk_ops("bp", 8'h11, 8'h22, 8'h33, 8'h44);
`ifndef OPERAND_DOUBLE_BUF_EN
      chk("bp_inready", {31'd0, in_ready}, 32'd0);
      chk("bp_idx", {30'd0, word_idx}, 32'd0);
`endif
    end
    in_val = 1'b0;
`ifdef OPERAND_DOUBLE_BUF_EN
    // The 0xAA words formed a second set; drain both sets.
    chk("bp_inready_dbl", {31'd0, in_ready}, 32'd0);
    op_ready = 1'b1;
    @(negedge clk);
    chk_ops("bp_second", 8'hAA, 8'hAA, 8'hAA, 8'hAA);
    @(negedge clk);
    chk("bp_drain_opval", {31'd0, op_val}, 32'd0);
`else
    op_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_opval", {31'd0, op_val}, 32'd0);
    chk("bp_release_idx", {30'd0, word_idx}, 32'd0);
`endif

    // Two sets in order.
    op_ready = 1'b0;
    feed4(8'h01, 8'h02, 8'h03, 8'h04);
    chk_ops("two_first", 8'h01, 8'h02, 8'h03, 8'h04);
`ifdef OPERAND_DOUBLE_BUF_EN
    chk("two_inready_mid", {31'd0, in_ready}, 32'd1);
    feed4(8'h09, 8'h08, 8'h07, 8'h06);
    chk("two_inready_full", {31'd0, in_ready}, 32'd0);
    chk_ops("two_first_hold", 8'h01, 8'h02, 8'h03, 8'h04);
    op_ready = 1'b1;
    @(negedge clk);
    chk("two_opval_second", {31'd0, op_val}, 32'd1);
    chk_ops("two_second", 8'h09, 8'h08, 8'h07, 8'h06);
    @(negedge clk);
    chk("two_opval_end", {31'd0, op_val}, 32'd0);
`else
    in_val = 1'b1; in_data = 8'h09;
    @(negedge clk);
    chk("two_blocked_idx", {30'd0, word_idx}, 32'd0);
    op_ready = 1'b1;
    in_val = 1'b0;
    @(negedge clk);
    chk("two_opval_gap", {31'd0, op_val}, 32'd0);
    op_ready = 1'b0;
    feed4(8'h09, 8'h08, 8'h07, 8'h06);
    chk("two_opval_second", {31'd0, op_val}, 32'd1);
    chk_ops("two_second", 8'h09, 8'h08, 8'h07, 8'h06);
    op_ready = 1'b1;
    @(negedge clk);
    chk("two_opval_end", {31'd0, op_val}, 32'd0);
`endif

    // Software reset mid-collection, asserted together with a valid word.
    in_val = 1'b1; in_data = 8'h55; @(negedge clk);
    in_data = 8'h66; @(negedge clk);
    chk("swr_idx_before", {30'd0, word_idx}, 32'd2);
    in_data = 8'h77; sw_rst = 1'b1;
    @(negedge clk);
    sw_rst = 1'b0; in_val = 1'b0;
    chk("swr_idx", {30'd0, word_idx}, 32'd0);
    chk("swr_opval", {31'd0, op_val}, 32'd0);
    op_ready = 1'b0;
    feed4(8'h10, 8'h11, 8'h12, 8'h13);
    chk("swr_set_opval", {31'd0, op_val}, 32'd1);
    chk_ops("swr_set", 8'h10, 8'h11, 8'h12, 8'h13);

    // Asynchronous reset while a second set is pending.
    feed4(8'hA1, 8'hB2, 8'hC3, 8'hD4);
    #2 rstn = 1'b0;
    #1;
    chk("arst_opval", {31'd0, op_val}, 32'd0);
    chk("arst_idx", {30'd0, word_idx}, 32'd0);
    chk_ops("arst", 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("arst_inready", {31'd0, in_ready}, 32'd1);
    chk("arst_opval_after", {31'd0, op_val}, 32'd0);

    // in_val toggling every cycle with junk on invalid cycles.
    alt[0] = 8'hFF; alt[1] = 8'h00; alt[2] = 8'hFF; alt[3] = 8'h00;
    op_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_val  = (i % 2 == 0);
      in_data = (i % 2 == 0) ? alt[i/2] : 8'h5A;
      @(negedge clk);
      acc = i / 2 + 1;
      chk("tog_idx", {30'd0, word_idx}, acc % 4);
      chk("tog_opval", {31'd0, op_val}, (acc == 4) ? 32'd1 : 32'd0);
    end
    in_val = 1'b0;
    chk_ops("tog", 8'hFF, 8'h00, 8'hFF, 8'h00);
    op_ready = 1'b1;
    @(negedge clk);
    chk("tog_opval_end", {31'd0, op_val}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of each operand part and of in_data.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port sw_rst  input  1  software reset, synchronous, active-high.
REQ-005 SHALL have port in_data  input  DATA_WIDTH  serial operand word.
REQ-006 SHALL have port in_val  input  1  in_data valid.
REQ-007 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-008 SHALL have ports op_1_re, op_1_im, op_2_re, op_2_im  output  DATA_WIDTH each  assembled unsigned operand parts.
REQ-009 SHALL have port op_val  output  1  complete operand set presented.
REQ-010 SHALL have port op_ready  input  1  downstream multiplier accepts the set.
REQ-011 SHALL have port word_idx  output  2  index of next word expected (0..3).

Function
REQ-012 Word accepted at a rising edge iff in_val and in_ready are both 1; otherwise in_data is ignored.
REQ-013 Fixed word order: idx 0 -> op_1_re, 1 -> op_1_im, 2 -> op_2_re, 3 -> op_2_im.
REQ-014 word_idx increments by 1 per accepted word and wraps 3 -> 0; it does not change without an acceptance.
REQ-015 Accepting word idx 3 completes a set; op_val SHALL be 1 from the edge that captured it (latency 1 cycle after the accepting cycle).
REQ-016 Set transfer occurs at a rising edge iff op_val and op_ready are both 1.
REQ-017 While op_val=1 and no transfer, op_val and all four operand outputs SHALL hold stable.
REQ-018 op_val SHALL never depend combinationally on op_ready; in_ready SHALL never depend combinationally on in_val.
REQ-019 Output state machine: EMPTY (op_val=0) -> FULL on set completion; FULL -> EMPTY on transfer with no new completion same edge.
REQ-020 Partially collected words (idx 1..3) SHALL NOT be visible as a set; op_val stays 0 until word idx 3 accepted.
REQ-021 in_val=1 held while in_ready=0 SHALL not lose or duplicate words; data is captured only on the accepting edge.

Reset
REQ-022 rstn=0 asynchronously: op_val=0, word_idx=0, operand outputs=0, all buffers empty; in_ready=1 after release.
REQ-023 sw_rst=1 at an edge has the same effect synchronously and overrides any simultaneous acceptance or transfer.
REQ-024 Reset mid-collection or with a pending set SHALL discard all partial and pending data.

Configuration
REQ-025 Macro OPERAND_DOUBLE_BUF_EN selects buffering depth.
REQ-026 Without OPERAND_DOUBLE_BUF_EN: single set buffer; in_ready = (op_val==0); after idx 3 accepted, in_ready=0 until the transfer edge; max throughput one set per 5 cycles.
REQ-027 With OPERAND_DOUBLE_BUF_EN: one presented set plus one collecting set; in_ready=0 only when a complete set is presented and a second complete set is also waiting.
REQ-028 With OPERAND_DOUBLE_BUF_EN: transfer and completion on the same edge SHALL present the newly completed set next cycle with op_val staying 1; sets leave in arrival order; max throughput one set per 4 cycles.

Verification
REQ-029 Feed 0x03,0x04,0x05,0x06 back-to-back, op_ready=1 -> op_val=1 one cycle after last word, outputs 3/4/5/6, op_val=0 after transfer edge.
REQ-030 Complete set, hold op_ready=0 for 10 cycles while in_val=1 with 0xAA -> outputs stable, op_val=1; in_ready=0 (single buf) and no 0xAA captured.
REQ-031 Two sets 1,2,3,4 then 9,8,7,6 with op_ready=0 until both sent (double buf) -> in_ready=0 after second set complete; outputs 1/2/3/4 then 9/8/7/6 in order.
REQ-032 Accept 2 words, assert sw_rst one cycle -> word_idx=0, op_val=0; next 4 words 0x10..0x13 form a clean set.
REQ-033 Assert rstn=0 asynchronously mid-cycle with op_val=1 -> op_val, word_idx, outputs 0 immediately; in_ready=1 after release.
REQ-034 Values 0xFF,0x00,0xFF,0x00 with in_val toggling every cycle -> exactly four words captured, outputs 255/0/255/0, word_idx wraps to 0.
